// File: rtl/clk_div_pkg.sv
// Purpose : shared types and constants for the enable-stream clock divider.
// Latency : n/a (definitions only).
// Backpr. : n/a.
package clk_div_pkg;

    // Default width of the divide-ratio register.
    localparam int DIV_WIDTH_DEFAULT = 8;

    // RUN   : counting, en_o pulses once per period.
    // GATED : enable stream stopped, waiting for gate_req_i to drop.
    // WAKE  : single-cycle restart slot before counting resumes from zero.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } clk_div_state_e;

endpackage : clk_div_pkg

// File: rtl/clk_div_en_gen.sv
// Purpose : divide-by-N enable generator for a downstream clock-gating cell,
//           with a level request/ack pair that parks the stream low.
// Latency : en_o/gate_ack_o are registered; en_o pulses on the wrap edge.
// Backpr. : div_ready_o only on wrap edges (RUN) or while GATED; never in WAKE.
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   div_i        requested divide ratio N (0 and 1 both mean divide-by-1)
//   div_valid_i  div_i valid
//   div_ready_o  divider update accepted this cycle (combinational)
//   gate_req_i   level request to stop the enable stream
//   gate_ack_o   enable stream stopped (en_o held low)
//   en_o         registered enable toward the gating latch
module clk_div_en_gen
    import clk_div_pkg::*;
#(
    parameter int DivWidth = DIV_WIDTH_DEFAULT,
    parameter int ResetDiv = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DivWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    input  logic                gate_req_i,
    output logic                gate_ack_o,
    output logic                en_o
);

    clk_div_state_e      r_state;
    logic [DivWidth-1:0] r_cnt;
    logic [DivWidth-1:0] r_div_q;
    logic                r_en;
    logic                r_ack;

    clk_div_state_e      w_state_nxt;
    logic [DivWidth-1:0] w_cnt_nxt;
    logic [DivWidth-1:0] w_div_nxt;
    logic                w_en_nxt;
    logic                w_ack_nxt;

    logic [DivWidth-1:0] w_div_eff;
    logic                w_wrap;
    logic                w_div_ready;
    logic                w_div_load;

    // A stored ratio of zero is treated as divide-by-1.
    assign w_div_eff   = (r_div_q == '0) ? DivWidth'(1) : r_div_q;
    assign w_wrap      = (r_state == ST_RUN) && (r_cnt == w_div_eff - DivWidth'(1));
    // Updates land only where they cannot truncate or stretch a period:
    // on the wrap edge (counter restarts anyway) or while parked.
    assign w_div_ready = (r_state == ST_GATED) || w_wrap;
    assign w_div_load  = w_div_ready && div_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = 1'b0;
        w_ack_nxt   = r_ack;
        w_div_nxt   = w_div_load ? div_i : r_div_q;

        case (r_state)
            ST_RUN: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    // gate_req_i is only looked at here, so short requests
                    // between wrap edges are ignored by construction.
                    if (gate_req_i) begin
                        w_state_nxt = ST_GATED;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_en_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DivWidth'(1);
                end
            end
            ST_GATED: begin
                w_cnt_nxt = '0;
                if (!gate_req_i) begin
                    w_state_nxt = ST_WAKE;
                    w_ack_nxt   = 1'b0;
                end
            end
            ST_WAKE: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
                w_ack_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_div_q <= DivWidth'(ResetDiv);
            r_en    <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div_q <= w_div_nxt;
            r_en    <= w_en_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign div_ready_o = w_div_ready;
    // Straight from flops so the gating latch never sees a combinational glitch.
    assign en_o        = r_en;
    assign gate_ack_o  = r_ack;

endmodule : clk_div_en_gen
